// File: rtl/proj_div_seq.sv
// Signed restoring divider for perspective projection; clamps num/den into [0, limit].
// Latency: request accepted at edge 0, out_valid rises after edge NUM_W+1; one request in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then IDLE next cycle.
module proj_div_seq #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 13,
    parameter int OUT_W = 10,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    input  logic [OUT_W-1:0] limit,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] answer,
    output logic             sat,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               fin;      // all quotient bits produced; next CALC edge enters DONE
    logic [NUM_W-1:0]   quo;      // holds |num| on capture, shifts quotient bits in from the LSB
    logic [DEN_W:0]     rem;      // partial remainder, one bit wider than the divisor
    logic [DEN_W-1:0]   dena;     // |den|
    logic               neg;
    logic               dz;
    logic               numpos;
    logic [OUT_W-1:0]   lim;
    logic [TAG_W-1:0]   tag;

    logic [NUM_W-1:0]   num_abs;
    logic [DEN_W-1:0]   den_abs;
    logic [DEN_W:0]     trial;
    logic               ge;
    logic [DEN_W:0]     rem_nxt;
    logic [NUM_W-1:0]   quo_nxt;
    logic [OUT_W-1:0]   res_ans;
    logic               res_sat;

    // Operand magnitudes; the unsigned width makes the most negative value exact.
    always_comb begin
        num_abs = num[NUM_W-1] ? (~num + NUM_W'(1)) : num;
        den_abs = den[DEN_W-1] ? (~den + DEN_W'(1)) : den;
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial   = {rem[DEN_W-1:0], quo[NUM_W-1]};
        ge      = (trial >= {1'b0, dena});
        rem_nxt = ge ? (trial - {1'b0, dena}) : trial;
        quo_nxt = {quo[NUM_W-2:0], ge};
    end

    // Clamp decision on the finished magnitude quotient; divide-by-zero wins, then sign, then range.
    always_comb begin
        res_ans = quo[OUT_W-1:0];
        res_sat = 1'b0;
        if (dz) begin
            res_ans = numpos ? lim : '0;
            res_sat = 1'b1;
        end else if (neg && (quo != '0)) begin
            res_ans = '0;
            res_sat = 1'b1;
        end else if (quo > {{(NUM_W-OUT_W){1'b0}}, lim}) begin
            res_ans = lim;
            res_sat = 1'b1;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fin       <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            dena      <= '0;
            neg       <= 1'b0;
            dz        <= 1'b0;
            numpos    <= 1'b0;
            lim       <= '0;
            tag       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            answer    <= '0;
            sat       <= 1'b0;
            tag_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quo      <= num_abs;
                        dena     <= den_abs;
                        rem      <= '0;
                        neg      <= num[NUM_W-1] ^ den[DEN_W-1];
                        dz       <= (den == '0);
                        numpos   <= !num[NUM_W-1] && (num != '0);
                        lim      <= limit;
                        tag      <= tag_in;
                        cnt      <= '0;
                        fin      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (!fin) begin
                        // Iteration runs even for den == 0 so latency never varies.
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        if (cnt == CNT_LAST) begin
                            fin <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        answer    <= res_ans;
                        sat       <= res_sat;
                        tag_out   <= tag;
                        out_valid <= 1'b1;
                        fin       <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // answer/sat/tag_out keep their values after leaving DONE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proj_div_seq.sv
// Bench for proj_div_seq: directed cases, random requests against an arithmetic model,
// backpressure hold, and asynchronous reset in the middle of a division.
module tb_proj_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] num;
    logic [12:0] den;
    logic [9:0]  limit;
    logic [0:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  answer;
    logic        sat;
    logic [0:0]  tag_out;

    int n_cmp = 0;
    int n_bad = 0;

    proj_div_seq #(.NUM_W(24), .DEN_W(13), .OUT_W(10), .TAG_W(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .limit     (limit),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .answer    (answer),
        .sat       (sat),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed division, then the clamp rules.
    function automatic void model(input logic [23:0] n, input logic [12:0] d, input logic [9:0] l,
                                  output logic [9:0] a, output logic s);
        longint nn, dd, q;
        nn = longint'($signed(n));
        dd = longint'($signed(d));
        if (dd == 0) begin
            a = (nn > 0) ? l : 10'd0;
            s = 1'b1;
        end else begin
            q = nn / dd;
            if (q < 0) begin
                a = 10'd0; s = 1'b1;
            end else if (q > longint'(l)) begin
                a = l; s = 1'b1;
            end else begin
                a = q[9:0]; s = 1'b0;
            end
        end
    endfunction

    // Present one request when in_ready; returns at the falling edge after acceptance.
    task automatic start(input logic [23:0] n, input logic [12:0] d, input logic [9:0] l, input logic [0:0] t);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        num = n; den = d; limit = l; tag_in = t; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        num = 24'($urandom); den = 13'($urandom); limit = 10'($urandom); tag_in = 1'($urandom);
    endtask

    // Count rising edges after acceptance until out_valid; 200 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic issue(input logic [23:0] n, input logic [12:0] d, input logic [9:0] l, input logic [0:0] t,
                         output logic [9:0] a, output logic s, output logic [0:0] tg, output int lat);
        start(n, d, l, t);
        wait_valid(lat);
        a = answer; s = sat; tg = tag_out;
        release_out();
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (answer !== 10'd0)   begin n_bad++; $display("FAIL reset_answer got %0d want 0", answer); end
        n_cmp++; if (sat !== 1'b0)       begin n_bad++; $display("FAIL reset_sat got %b want 0", sat); end
        n_cmp++; if (tag_out !== 1'b0)   begin n_bad++; $display("FAIL reset_tag got %b want 0", tag_out); end
    endtask

    // Hand-derived cases: exact limit, over range, signs, divide by zero, most negative numerator.
    task automatic test_directed();
        int tn[11] = '{6400, 6410, 100000, -500, 500, -500, -5, 100, -3, 0, -8388608};
        int td[11] = '{10, 10, 7, 10, -10, -10, 10, 0, 0, 0, -1};
        int tl[11] = '{640, 640, 480, 640, 640, 640, 640, 640, 640, 640, 640};
        int tt[11] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        int ea[11] = '{640, 640, 480, 0, 0, 50, 0, 640, 0, 0, 640};
        int es[11] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
        logic [23:0] n; logic [12:0] d; logic [9:0] l; logic [0:0] t;
        logic [9:0] a; logic s; logic [0:0] tg; int lat;
        for (int i = 0; i < 11; i++) begin
            n = tn[i][23:0]; d = td[i][12:0]; l = tl[i][9:0]; t = tt[i][0:0];
            issue(n, d, l, t, a, s, tg, lat);
            n_cmp++; if (a !== ea[i][9:0]) begin n_bad++; $display("FAIL directed%0d_answer got %0d want %0d", i, a, ea[i]); end
            n_cmp++; if (s !== es[i][0])   begin n_bad++; $display("FAIL directed%0d_sat got %b want %b", i, s, es[i][0]); end
            n_cmp++; if (tg !== t)         begin n_bad++; $display("FAIL directed%0d_tag got %b want %b", i, tg, t); end
            n_cmp++; if (lat !== 25)       begin n_bad++; $display("FAIL directed%0d_latency got %0d want 25", i, lat); end
        end
    endtask

    task automatic test_random();
        logic [23:0] n; logic [12:0] d; logic [9:0] l; logic [0:0] t;
        logic [9:0] a, ea; logic s, es; logic [0:0] tg; int lat;
        for (int i = 0; i < 40; i++) begin
            n = ($urandom_range(0, 1) == 0) ? 24'($urandom) : 24'($signed(20'($urandom)));
            case ($urandom_range(0, 3))
                0:       d = 13'($signed(13'($urandom_range(0, 40)) - 13'd20));
                1:       d = 13'($urandom_range(1, 4095));
                default: d = 13'($urandom);
            endcase
            l = 10'($urandom);
            t = 1'($urandom);
            model(n, d, l, ea, es);
            issue(n, d, l, t, a, s, tg, lat);
            n_cmp++; if (a !== ea)   begin n_bad++; $display("FAIL random%0d_answer num=%0d den=%0d lim=%0d got %0d want %0d", i, $signed(n), $signed(d), l, a, ea); end
            n_cmp++; if (s !== es)   begin n_bad++; $display("FAIL random%0d_sat num=%0d den=%0d got %b want %b", i, $signed(n), $signed(d), s, es); end
            n_cmp++; if (tg !== t)   begin n_bad++; $display("FAIL random%0d_tag got %b want %b", i, tg, t); end
            n_cmp++; if (lat !== 25) begin n_bad++; $display("FAIL random%0d_latency got %0d want 25", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] ea; logic es; int lat; bit ghost = 0;
        model(24'd3000, 13'd7, 10'd480, ea, es);
        start(24'd3000, 13'd7, 10'd480, 1'b1);
        wait_valid(lat);
        n_cmp++; if (lat !== 25) begin n_bad++; $display("FAIL bp_latency got %0d want 25", lat); end
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                num = 24'd50; den = 13'd5; limit = 10'd100; tag_in = 1'b0; in_valid = 1'b1;
            end
            if (k == 5) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (answer !== ea)     begin n_bad++; $display("FAIL bp%0d_answer got %0d want %0d", k, answer, ea); end
            n_cmp++; if (sat !== es)        begin n_bad++; $display("FAIL bp%0d_sat got %b want %b", k, sat, es); end
            n_cmp++; if (tag_out !== 1'b1)  begin n_bad++; $display("FAIL bp%0d_tag got %b want 1", k, tag_out); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp%0d_in_ready got %b want 0", k, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d_out_valid got %b want 1", k, out_valid); end
        end
        release_out();
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        n_cmp++; if (answer !== ea)      begin n_bad++; $display("FAIL bp_retain_answer got %0d want %0d", answer, ea); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) ghost = 1;
        end
        n_cmp++; if (ghost !== 1'b0) begin n_bad++; $display("FAIL bp_ignored_request got %b want 0", ghost); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] a; logic s; logic [0:0] tg; int lat; bit ghost = 0;
        start(24'd1000, 13'd3, 10'd640, 1'b1);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) ghost = 1;
        end
        n_cmp++; if (ghost !== 1'b0) begin n_bad++; $display("FAIL midrst_abandoned got %b want 0", ghost); end
        issue(24'd1234, 13'd2, 10'd640, 1'b0, a, s, tg, lat);
        n_cmp++; if (a !== 10'd617) begin n_bad++; $display("FAIL midrst_answer got %0d want 617", a); end
        n_cmp++; if (s !== 1'b0)    begin n_bad++; $display("FAIL midrst_sat got %b want 0", s); end
        n_cmp++; if (lat !== 25)    begin n_bad++; $display("FAIL midrst_latency got %0d want 25", lat); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num = '0; den = '0; limit = '0; tag_in = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
